// File: rtl/r_ptr_empty_handler_if.sv
// Read-side pointer/flag bundle of the async FIFO. The DUT takes the slave modport.
// The occupancy signals exist only when R_ALMOST_EMPTY_EN is defined.
interface r_ptr_empty_handler_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  r_inc;
  logic [ADDR_WIDTH:0]   w_gr_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   gr_r_ptr;
  logic [ADDR_WIDTH:0]   sync_gr_w_ptr;
  logic                  r_empty;
`ifdef R_ALMOST_EMPTY_EN
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_almost_empty;

  modport master (
    output r_inc, w_gr_ptr,
    input  r_addr, gr_r_ptr, sync_gr_w_ptr, r_empty, r_level, r_almost_empty
  );
  modport slave (
    input  r_inc, w_gr_ptr,
    output r_addr, gr_r_ptr, sync_gr_w_ptr, r_empty, r_level, r_almost_empty
  );
`else
  modport master (
    output r_inc, w_gr_ptr,
    input  r_addr, gr_r_ptr, sync_gr_w_ptr, r_empty
  );
  modport slave (
    input  r_inc, w_gr_ptr,
    output r_addr, gr_r_ptr, sync_gr_w_ptr, r_empty
  );
`endif
endinterface

// File: rtl/r_ptr_empty_handler.sv
// Read-domain pointer/empty stage of the async FIFO: write-pointer synchroniser, read pointers, registered empty.
// Optional macro R_ALMOST_EMPTY_EN adds registered r_level and r_almost_empty.
module r_ptr_empty_handler #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                   r_clk,
  input  logic                   r_rst,
  r_ptr_empty_handler_if.slave   bus
);
  localparam int PW = ADDR_WIDTH + 1;

  if (SYNC_STAGES < 2 || AE_THRESH < 0) begin : g_bad_param
    $error("r_ptr_empty_handler: SYNC_STAGES must be >= 2 and AE_THRESH >= 0");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_out;
  logic [PW-1:0] r_bin_q, r_bin_d;
  logic [PW-1:0] r_gr_q,  r_gr_d;
  logic          r_empty_q, r_empty_d;

  // Plain flop chain: nothing may sit between stages of the CDC synchroniser.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.w_gr_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    r_bin_d   = r_bin_q + PW'(bus.r_inc & ~r_empty_q);
    r_gr_d    = r_bin_d ^ (r_bin_d >> 1);
    r_empty_d = (r_gr_d == sync_out);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin_q   <= '0;
      r_gr_q    <= '0;
      r_empty_q <= 1'b1;
    end else begin
      r_bin_q   <= r_bin_d;
      r_gr_q    <= r_gr_d;
      r_empty_q <= r_empty_d;
    end
  end

  assign bus.r_addr        = r_bin_q[ADDR_WIDTH-1:0];
  assign bus.gr_r_ptr      = r_gr_q;
  assign bus.sync_gr_w_ptr = sync_out;
  assign bus.r_empty       = r_empty_q;

`ifdef R_ALMOST_EMPTY_EN
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] w_bin;
  logic [PW-1:0] level_d;
  logic [PW-1:0] level_q;
  logic          almost_empty_q;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
    assign w_bin[gi] = ^(sync_out >> gi);
  end

  assign level_d = w_bin - r_bin_d;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      level_q        <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      level_q        <= level_d;
      almost_empty_q <= (level_d <= AE_T);
    end
  end

  assign bus.r_level        = level_q;
  assign bus.r_almost_empty = almost_empty_q;
`endif
endmodule
